ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Parametrised arbiter that shares one `basic_ram`-style port (cs/we/oe, address, data in/out, done) among `NUM_MASTERS` requesters. It replaces the static `ld_file` mux between the file loader and the ARMv4 core in the top-level test harness. It adds fixed-priority or round-robin arbitration, a force-owner override for memory preload, per-master completion handshakes, and a wait-state timeout.

## Interface
Parameters:
- `NUM_MASTERS`, 2, number of requesting ports (≥2).
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width.
- `ARB_MODE`, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- `TIMEOUT`, 255, maximum ACCESS cycles waiting for `ram_ready` before abort (≥1).
- `SEL_W`, $clog2(NUM_MASTERS), width of `force_sel`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `m_cs`  in  NUM_MASTERS  per-master request/chip select.
- `m_we`  in  NUM_MASTERS  per-master write enable.
- `m_oe`  in  NUM_MASTERS  per-master output enable.
- `m_addr`  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `m_d_in`  in  NUM_MASTERS*DATA_WIDTH  packed write data, same packing.
- `m_d_out`  out  DATA_WIDTH  registered read data, shared by all masters.
- `m_ready`  out  NUM_MASTERS  one-hot, 1-cycle completion pulse.
- `m_timeout`  out  NUM_MASTERS  one-hot, 1-cycle abort pulse.
- `m_grant`  out  NUM_MASTERS  one-hot current owner; all-zero when idle.
- `force_en`  in  1  restrict eligibility to `force_sel`.
- `force_sel`  in  SEL_W  forced owner index.
- `ram_addr`  out  ADDR_WIDTH  to RAM.
- `ram_d_in`  out  DATA_WIDTH  to RAM.
- `ram_d_out`  in  DATA_WIDTH  from RAM.
- `ram_cs`, `ram_we`, `ram_oe`  out  1 each  to RAM.
- `ram_ready`  in  1  RAM access complete (`mem_done_out`).

## Operation
- FSM states: IDLE, ACCESS, RELEASE.
- IDLE:
  - Eligible set is `m_cs`, masked to bit `force_sel` when `force_en`=1.
  - If the set is non-empty, register the winner into `m_grant` and go to ACCESS.
- Winner selection:
  - Mode 0: lowest eligible index.
  - Mode 1: first eligible index at or after `rr_ptr`, modulo NUM_MASTERS.
- ACCESS:
  - `ram_*` outputs are combinationally muxed from the granted master's cs/we/oe/addr/d_in.
  - The wait counter increments each cycle.
  - The granted master must hold its signals stable until `m_ready` or `m_timeout`.
- Exits from ACCESS, all going to RELEASE:
  - `ram_ready`=1: latch `ram_d_out` into `m_d_out` and pulse `m_ready[g]`.
  - Granted master drops `m_cs`: abandon the access; no pulse.
  - Counter reaches TIMEOUT with no `ram_ready`: pulse `m_timeout[g]`.
  - `ram_ready` and timeout in the same cycle: ready wins.
- RELEASE, one cycle:
  - `ram_cs`/`ram_we`/`ram_oe` are 0 so the RAM sees an access boundary.
  - `m_grant` is cleared.
  - In mode 1, `rr_ptr` becomes (g+1) mod NUM_MASTERS after a completion or timeout. It is unchanged on abandonment.
  - Go to IDLE.
- `force_en` changes take effect only at IDLE selection. An in-flight access by another master is never preempted.
- Write data does not pass through `m_d_out`; it updates only on read completions (`m_oe`=1 at completion).
- Outside ACCESS, `ram_addr` and `ram_d_in` are 0.

## Timing
- Reset values:
  - State IDLE; `rr_ptr`=0; counter=0.
  - `m_grant`=0, `m_ready`=0, `m_timeout`=0, `m_d_out`=0.
  - All `ram_*` outputs 0.
- A reset asserted mid-ACCESS returns to IDLE at the next edge, with no pulse to the master.
- Request latency: `m_cs[i]` high at edge k in IDLE gives `m_grant[i]` and `ram_cs` high in cycle k+1.
- Completion: `ram_ready` sampled high at edge j gives `m_ready[g]`=1 and valid `m_d_out` during cycle j+1 (the RELEASE cycle).
- Minimum access: 3 cycles (IDLE, ACCESS, RELEASE) when `ram_ready` is high in the first ACCESS cycle.
- Back-to-back throughput: one access per 3 cycles.
- Timeout: `m_timeout` asserts TIMEOUT+1 cycles after grant.
- A master holding `m_cs` after `m_ready` is treated as a new request at the following IDLE.

## Test plan
- Single read, fixed priority:
  - Stimulus: master 1 reads addr 0x10, RAM ready 2 cycles after cs, data 0xDEADBEEF.
  - Response: `m_grant`=2'b10; `m_ready[1]` pulses once; `m_d_out`=0xDEADBEEF; `ram_cs` low for exactly 1 cycle afterwards.
- Contention, mode 0:
  - Stimulus: masters 0 and 1 request continuously.
  - Response: master 0 wins every arbitration; master 1 is never granted.
- Contention, mode 1 (NUM_MASTERS=3):
  - Stimulus: all three masters request continuously.
  - Response: grant order 0,1,2,0,1,2, with an access every 3 cycles at ready-in-1.
- Force override:
  - Stimulus: `force_en`=1, `force_sel`=1 (loader), master 0 requesting; then drop `force_en`.
  - Response: only master 1 is granted while `force_en`=1; master 0 is served at the next IDLE after the drop.
- Timeout:
  - Stimulus: TIMEOUT=4, `ram_ready` held 0.
  - Response: `m_timeout[g]` pulses 5 cycles after grant; no `m_ready`.
  - Stimulus: `ram_ready` rises on the timeout cycle.
  - Response: `m_ready` pulses, not `m_timeout`.
- Reset mid-access:
  - Stimulus: `rst`=1 during ACCESS.
  - Response: next cycle all outputs are 0 and `m_d_out`=0; a request after reset is granted with normal latency.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares one basic_ram-style port among NUM_MASTERS requesters. Each access
// walks IDLE -> ACCESS -> RELEASE. ACCESS ends on RAM ready, on the owner
// dropping cs, or on a wait-state timeout. Arbitration is either fixed
// priority or round-robin, and a force override narrows the eligible set.
module ram_port_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT     = 255,
  parameter int SEL_W       = $clog2(NUM_MASTERS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_cs,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS-1:0]            m_oe,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_d_in,
  output logic [DATA_WIDTH-1:0]             m_d_out,
  output logic [NUM_MASTERS-1:0]            m_ready,
  output logic [NUM_MASTERS-1:0]            m_timeout,
  output logic [NUM_MASTERS-1:0]            m_grant,
  input  logic                              force_en,
  input  logic [SEL_W-1:0]                  force_sel,
  output logic [ADDR_WIDTH-1:0]             ram_addr,
  output logic [DATA_WIDTH-1:0]             ram_d_in,
  input  logic [DATA_WIDTH-1:0]             ram_d_out,
  output logic                              ram_cs,
  output logic                              ram_we,
  output logic                              ram_oe,
  input  logic                              ram_ready
);

  // Wide enough to hold TIMEOUT itself; the counter stops there.
  localparam int CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRelease
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]        gidx_q, gidx_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [SEL_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_MASTERS-1:0]  ready_q, ready_d;
  logic [NUM_MASTERS-1:0]  timeout_q, timeout_d;
  logic [DATA_WIDTH-1:0]   d_out_q, d_out_d;

  logic [NUM_MASTERS-1:0]  eligible;
  logic [NUM_MASTERS-1:0]  winner;
  logic [SEL_W-1:0]        win_idx;
  logic                    win_found;

  logic                    g_cs, g_we, g_oe;
  logic [ADDR_WIDTH-1:0]   g_addr;
  logic [DATA_WIDTH-1:0]   g_din;
  logic [SEL_W-1:0]        next_ptr;
  logic                    in_access;

  // Eligible set and winner; loops run high-to-low so the best candidate is written last.
  always_comb begin : pick_winner
    int idx;
    eligible  = m_cs;
    winner    = '0;
    win_idx   = '0;
    win_found = 1'b0;
    idx       = 0;
    if (force_en) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (SEL_W'(i) != force_sel) eligible[i] = 1'b0;
      end
    end
    if (ARB_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          winner    = '0;
          winner[i] = 1'b1;
          win_idx   = SEL_W'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int o = NUM_MASTERS - 1; o >= 0; o--) begin
        idx = (int'(rr_ptr_q) + o) % NUM_MASTERS;
        if (eligible[idx]) begin
          winner      = '0;
          winner[idx] = 1'b1;
          win_idx     = SEL_W'(idx);
          win_found   = 1'b1;
        end
      end
    end
  end

  // One-hot mux of the granted master's request signals.
  always_comb begin : grant_mux
    g_cs   = |(m_cs & grant_q);
    g_we   = |(m_we & grant_q);
    g_oe   = |(m_oe & grant_q);
    g_addr = '0;
    g_din  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        g_addr = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        g_din  = m_d_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // RAM side is only driven during ACCESS; RELEASE and IDLE present an idle port.
  always_comb begin : ram_drive
    in_access = (state_q == StAccess);
    ram_cs    = in_access & g_cs;
    ram_we    = in_access & g_we;
    ram_oe    = in_access & g_oe;
    ram_addr  = in_access ? g_addr : '0;
    ram_d_in  = in_access ? g_din : '0;
  end

  assign next_ptr = (gidx_q == SEL_W'(NUM_MASTERS - 1)) ? '0 : gidx_q + SEL_W'(1);

  // Next-state logic for the access FSM and its datapath registers.
  always_comb begin : fsm_next
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    ready_d   = '0;
    timeout_d = '0;
    d_out_d   = d_out_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (win_found) begin
          grant_d = winner;
          gidx_d  = win_idx;
          state_d = StAccess;
        end
      end
      StAccess: begin
        cnt_d = cnt_q + CntW'(1);
        if (!g_cs) begin
          // Owner walked away: end quietly.
          grant_d = '0;
          state_d = StRelease;
        end else if (ram_ready) begin
          // Ready beats a coincident timeout; only reads update m_d_out.
          ready_d = grant_q;
          if (g_oe) d_out_d = ram_d_out;
          grant_d = '0;
          state_d = StRelease;
        end else if (cnt_q == TimeoutVal) begin
          timeout_d = grant_q;
          grant_d   = '0;
          state_d   = StRelease;
        end
      end
      StRelease: begin
        cnt_d   = '0;
        state_d = StIdle;
        // Pointer advances only after a real completion or abort, not abandonment.
        if ((ARB_MODE == 1) && ((|ready_q) || (|timeout_q))) rr_ptr_d = next_ptr;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      gidx_q    <= '0;
      cnt_q     <= '0;
      rr_ptr_q  <= '0;
      ready_q   <= '0;
      timeout_q <= '0;
      d_out_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
      d_out_q   <= d_out_d;
    end
  end

  assign m_grant   = grant_q;
  assign m_ready   = ready_q;
  assign m_timeout = timeout_q;
  assign m_d_out   = d_out_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: instance A is 2 masters / fixed priority, instance B is
// 3 masters / round-robin; both use a 4-cycle timeout.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: NUM_MASTERS=2, ARB_MODE=0
  logic [1:0]  a_cs, a_we, a_oe, a_ready, a_to, a_grant;
  logic [63:0] a_addr, a_din;
  logic [31:0] a_dout, a_raddr, a_rdin, a_rdout;
  logic        a_fen, a_rcs, a_rwe, a_roe, a_rready;
  logic [0:0]  a_fsel;

  // Instance B: NUM_MASTERS=3, ARB_MODE=1
  logic [2:0]  b_cs, b_we, b_oe, b_ready, b_to, b_grant;
  logic [95:0] b_addr, b_din;
  logic [31:0] b_dout, b_raddr, b_rdin, b_rdout;
  logic        b_fen, b_rcs, b_rwe, b_roe, b_rready;
  logic [1:0]  b_fsel;

  ram_port_arbiter #(
    .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0), .TIMEOUT(4)
  ) dut_a (
    .clk(clk), .rst(rst), .m_cs(a_cs), .m_we(a_we), .m_oe(a_oe), .m_addr(a_addr),
    .m_d_in(a_din), .m_d_out(a_dout), .m_ready(a_ready), .m_timeout(a_to),
    .m_grant(a_grant), .force_en(a_fen), .force_sel(a_fsel), .ram_addr(a_raddr),
    .ram_d_in(a_rdin), .ram_d_out(a_rdout), .ram_cs(a_rcs), .ram_we(a_rwe),
    .ram_oe(a_roe), .ram_ready(a_rready)
  );

  ram_port_arbiter #(
    .NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1), .TIMEOUT(4)
  ) dut_b (
    .clk(clk), .rst(rst), .m_cs(b_cs), .m_we(b_we), .m_oe(b_oe), .m_addr(b_addr),
    .m_d_in(b_din), .m_d_out(b_dout), .m_ready(b_ready), .m_timeout(b_to),
    .m_grant(b_grant), .force_en(b_fen), .force_sel(b_fsel), .ram_addr(b_raddr),
    .ram_d_in(b_rdin), .ram_d_out(b_rdout), .ram_cs(b_rcs), .ram_we(b_rwe),
    .ram_oe(b_roe), .ram_ready(b_rready)
  );

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (a_grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", a_grant); end
    checks++;
    if ({a_ready, a_to} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses: got %b want 0000", {a_ready, a_to});
    end
    checks++;
    if (a_dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", a_dout); end
    checks++;
    if ({a_rcs, a_rwe, a_roe} !== 3'b000 || a_raddr !== 32'h0 || a_rdin !== 32'h0) begin
      errors++;
      $display("FAIL reset_ram: got cs/we/oe=%b addr=%h din=%h want 000/0/0",
               {a_rcs, a_rwe, a_roe}, a_raddr, a_rdin);
    end
    checks++;
    if (b_grant !== 3'b000 || b_dout !== 32'h0) begin
      errors++; $display("FAIL reset_b: got grant=%b dout=%h want 000/0", b_grant, b_dout);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    a_cs = 2'b10; a_oe = 2'b10; a_we = 2'b00;
    a_addr[32 +: 32] = 32'h10;
    a_rdout = 32'hDEADBEEF;
    tick();  // first ACCESS cycle
    checks++;
    if (a_grant !== 2'b10) begin errors++; $display("FAIL read_grant: got %b want 10", a_grant); end
    checks++;
    if ({a_rcs, a_rwe, a_roe} !== 3'b101 || a_raddr !== 32'h10) begin
      errors++;
      $display("FAIL read_ram: got cs/we/oe=%b addr=%h want 101/10", {a_rcs, a_rwe, a_roe}, a_raddr);
    end
    tick();  // second ACCESS cycle, RAM still busy
    checks++;
    if (a_ready !== 2'b00 || a_grant !== 2'b10) begin
      errors++; $display("FAIL read_wait: got ready=%b grant=%b want 00/10", a_ready, a_grant);
    end
    a_rready = 1'b1;
    tick();  // RELEASE
    checks++;
    if (a_ready !== 2'b10) begin errors++; $display("FAIL read_ready: got %b want 10", a_ready); end
    checks++;
    if (a_dout !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_dout: got %h want deadbeef", a_dout);
    end
    checks++;
    if (a_rcs !== 1'b0 || a_grant !== 2'b00) begin
      errors++; $display("FAIL read_release: got ram_cs=%b grant=%b want 0/00", a_rcs, a_grant);
    end
    a_rready = 1'b0; a_cs = 2'b00; a_oe = 2'b00;
    tick();  // IDLE
    checks++;
    if (a_ready !== 2'b00) begin errors++; $display("FAIL read_pulse_once: got %b want 00", a_ready); end
  endtask

  task automatic test_write_keeps_dout();
    a_cs = 2'b01; a_we = 2'b01; a_oe = 2'b00;
    a_addr[0 +: 32] = 32'h20;
    a_din[0 +: 32] = 32'h12345678;
    a_rdout = 32'hCAFEF00D;
    tick();
    checks++;
    if ({a_rcs, a_rwe, a_roe} !== 3'b110 || a_raddr !== 32'h20 || a_rdin !== 32'h12345678) begin
      errors++;
      $display("FAIL write_ram: got cs/we/oe=%b addr=%h din=%h want 110/20/12345678",
               {a_rcs, a_rwe, a_roe}, a_raddr, a_rdin);
    end
    a_rready = 1'b1;
    tick();
    checks++;
    if (a_ready !== 2'b01 || a_dout !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_done: got ready=%b dout=%h want 01/deadbeef", a_ready, a_dout);
    end
    checks++;
    if (a_rdin !== 32'h0 || a_raddr !== 32'h0) begin
      errors++; $display("FAIL write_release_bus: got addr=%h din=%h want 0/0", a_raddr, a_rdin);
    end
    a_rready = 1'b0; a_cs = 2'b00; a_we = 2'b00;
    tick();
  endtask

  task automatic test_contention_mode0();
    a_cs = 2'b11; a_oe = 2'b11; a_rready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (a_grant !== 2'b01) begin errors++; $display("FAIL prio_grant%0d: got %b want 01", n, a_grant); end
      tick();
      checks++;
      if (a_ready !== 2'b01) begin errors++; $display("FAIL prio_ready%0d: got %b want 01", n, a_ready); end
      tick();
    end
    a_cs = 2'b00; a_oe = 2'b00; a_rready = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    b_cs = 3'b111; b_oe = 3'b111; b_rready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      exp = 3'b001 << (n % 3);
      tick();
      checks++;
      if (b_grant !== exp || b_rcs !== 1'b1) begin
        errors++; $display("FAIL rr_grant%0d: got %b cs=%b want %b cs=1", n, b_grant, b_rcs, exp);
      end
      tick();
      checks++;
      if (b_ready !== exp) begin errors++; $display("FAIL rr_ready%0d: got %b want %b", n, b_ready, exp); end
      tick();
    end
    b_cs = 3'b000; b_oe = 3'b000; b_rready = 1'b0;
    tick();
  endtask

  task automatic test_abandon();
    b_cs = 3'b010;
    tick();
    checks++;
    if (b_grant !== 3'b010) begin errors++; $display("FAIL abandon_grant: got %b want 010", b_grant); end
    b_cs = 3'b000;
    tick();
    checks++;
    if (b_ready !== 3'b000 || b_to !== 3'b000 || b_rcs !== 1'b0) begin
      errors++;
      $display("FAIL abandon_quiet: got ready=%b to=%b cs=%b want 000/000/0", b_ready, b_to, b_rcs);
    end
    tick();
    // Pointer was 0 before the abandoned access and must still be 0.
    b_cs = 3'b111; b_rready = 1'b1;
    tick();
    checks++;
    if (b_grant !== 3'b001) begin errors++; $display("FAIL abandon_ptr: got %b want 001", b_grant); end
    tick();
    b_cs = 3'b000; b_rready = 1'b0;
    tick();
  endtask

  task automatic test_force();
    a_fen = 1'b1; a_fsel = 1'b1; a_cs = 2'b01; a_oe = 2'b01;
    tick();
    tick();
    checks++;
    if (a_grant !== 2'b00) begin errors++; $display("FAIL force_block: got %b want 00", a_grant); end
    a_cs = 2'b11; a_oe = 2'b11; a_rready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++;
      if (a_grant !== 2'b10) begin errors++; $display("FAIL force_grant%0d: got %b want 10", n, a_grant); end
      tick();
      tick();
    end
    a_fen = 1'b0;  // dropped while in IDLE
    tick();
    checks++;
    if (a_grant !== 2'b01) begin errors++; $display("FAIL force_drop: got %b want 01", a_grant); end
    tick();
    a_cs = 2'b00; a_oe = 2'b00; a_rready = 1'b0;
    tick();
  endtask

  task automatic test_timeout(input logic ready_last);
    a_cs = 2'b01; a_oe = 2'b01; a_rready = 1'b0;
    a_rdout = 32'h0BADF00D;
    tick();  // grant cycle
    checks++;
    if (a_grant !== 2'b01) begin errors++; $display("FAIL to_grant: got %b want 01", a_grant); end
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++;
      if (a_to !== 2'b00 || a_ready !== 2'b00) begin
        errors++; $display("FAIL to_early%0d: got to=%b ready=%b want 00/00", t, a_to, a_ready);
      end
    end
    a_rready = ready_last;
    tick();  // grant + 5
    checks++;
    if (ready_last) begin
      if (a_ready !== 2'b01 || a_to !== 2'b00 || a_dout !== 32'h0BADF00D) begin
        errors++;
        $display("FAIL to_ready_wins: got ready=%b to=%b dout=%h want 01/00/0badf00d",
                 a_ready, a_to, a_dout);
      end
    end else begin
      if (a_to !== 2'b01 || a_ready !== 2'b00 || a_grant !== 2'b00) begin
        errors++;
        $display("FAIL to_pulse: got to=%b ready=%b grant=%b want 01/00/00", a_to, a_ready, a_grant);
      end
    end
    a_cs = 2'b00; a_oe = 2'b00; a_rready = 1'b0;
    tick();
    checks++;
    if (a_to !== 2'b00) begin errors++; $display("FAIL to_once: got %b want 00", a_to); end
  endtask

  task automatic test_reset_mid_access();
    a_cs = 2'b10; a_oe = 2'b10; a_rdout = 32'h55AA55AA;
    tick();
    checks++;
    if (a_grant !== 2'b10) begin errors++; $display("FAIL rstmid_pre: got %b want 10", a_grant); end
    rst = 1'b1;
    tick();
    checks++;
    if (a_grant !== 2'b00 || a_ready !== 2'b00 || a_to !== 2'b00 || a_dout !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outs: got grant=%b ready=%b to=%b dout=%h want 00/00/00/0",
               a_grant, a_ready, a_to, a_dout);
    end
    checks++;
    if ({a_rcs, a_rwe, a_roe} !== 3'b000 || a_raddr !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_ram: got cs/we/oe=%b addr=%h want 000/0", {a_rcs, a_rwe, a_roe}, a_raddr);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (a_grant !== 2'b10 || a_rcs !== 1'b1) begin
      errors++; $display("FAIL rstmid_regrant: got grant=%b cs=%b want 10/1", a_grant, a_rcs);
    end
    a_rready = 1'b1;
    tick();
    checks++;
    if (a_ready !== 2'b10 || a_dout !== 32'h55AA55AA) begin
      errors++; $display("FAIL rstmid_done: got ready=%b dout=%h want 10/55aa55aa", a_ready, a_dout);
    end
    a_cs = 2'b00; a_oe = 2'b00; a_rready = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    a_cs = '0; a_we = '0; a_oe = '0; a_addr = '0; a_din = '0; a_rdout = '0;
    a_fen = 1'b0; a_fsel = '0; a_rready = 1'b0;
    b_cs = '0; b_we = '0; b_oe = '0; b_addr = '0; b_din = '0; b_rdout = 32'h1111_2222;
    b_fen = 1'b0; b_fsel = '0; b_rready = 1'b0;
    test_reset();
    test_single_read();
    test_write_keeps_dout();
    test_contention_mode0();
    test_round_robin();
    test_abandon();
    test_force();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
